ras: RTL

RAS -- requirements
Module: ras

---
 rtl/corep_pkg.sv | 12 +
 rtl/ras.sv | 97 +++++++++
 2 files changed

// File: rtl/corep_pkg.sv
// rtl/corep_pkg.sv - shared core types and constants for the branch-prediction front end
package corep;

    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);

    typedef logic [37:0]                PC38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;

    localparam PC38_t INIT_PC38 = 38'h0;

endpackage

// File: rtl/ras.sv
// rtl/ras.sv - circular return-address stack with zero-latency top read and checkpoint restore
// Optional occupancy counter and ret_empty flag: define RAS_OCCUPANCY_COUNT_EN.
module ras
    import corep::*;
#(
    parameter int    RAS_ENTRIES = corep::RAS_ENTRIES,
    parameter PC38_t INIT_PC38   = corep::INIT_PC38
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     link_valid,
    input  PC38_t    link_pc38,
    input  logic     ret_valid,
    output PC38_t    ret_pc38,
    output RAS_idx_t ras_index,
    input  logic     restore_valid,
`ifdef RAS_OCCUPANCY_COUNT_EN
    input  logic [LOG_RAS_ENTRIES:0] restore_count,
    output logic                     ret_empty,
`endif
    input  RAS_idx_t restore_ras_index
);

    PC38_t    entries_q [RAS_ENTRIES];
    RAS_idx_t idx_q, idx_d;
    logic     wr_en;
    RAS_idx_t wr_idx;

    // Restore wins outright; a call+return pair (RET_L) replaces the top in place.
    always_comb begin
        idx_d  = idx_q;
        wr_en  = 1'b0;
        wr_idx = idx_q;
        if (restore_valid) begin
            idx_d = restore_ras_index;
        end else if (link_valid && ret_valid) begin
            wr_en  = 1'b1;
            wr_idx = idx_q;
        end else if (link_valid) begin
            idx_d  = RAS_idx_t'(idx_q + 1'b1);
            wr_en  = 1'b1;
            wr_idx = RAS_idx_t'(idx_q + 1'b1);
        end else if (ret_valid) begin
            idx_d = RAS_idx_t'(idx_q - 1'b1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries_q[i] <= INIT_PC38;
            end
        end else begin
            idx_q <= idx_d;
            if (wr_en) begin
                entries_q[wr_idx] <= link_pc38;
            end
        end
    end

    assign ret_pc38  = entries_q[idx_q];
    assign ras_index = idx_q;

`ifdef RAS_OCCUPANCY_COUNT_EN
    localparam logic [LOG_RAS_ENTRIES:0] CNT_MAX = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

    logic [LOG_RAS_ENTRIES:0] cnt_q, cnt_d;

    // Counts live entries only; the pointer keeps wrapping independently of it.
    always_comb begin
        cnt_d = cnt_q;
        if (restore_valid) begin
            cnt_d = restore_count;
        end else if (link_valid && !ret_valid) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ret_valid && !link_valid) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ret_empty = (cnt_q == '0);
`endif

endmodule
